// File: rtl/seg7_pkg.sv
// Shared seven-segment pattern type and glyphs for the display drivers.
// Patterns are active-high, bit0 = segment a through bit6 = segment g.
package seg7_pkg;

   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG_BLANK = 7'h00;

   // Glyphs used by the team banner messages
   localparam seg7_t SEG_G = 7'h3D;
   localparam seg7_t SEG_O = 7'h5C;
   localparam seg7_t SEG_B = 7'h7C;
   localparam seg7_t SEG_U = 7'h3E;
   localparam seg7_t SEG_F = 7'h71;
   localparam seg7_t SEG_S = 7'h6D;

endpackage

// File: rtl/seg7_step_div.sv
// Step-rate divider: counts enabled cycles 0..DIV-1 and pulses tick on the
// terminal count. The count freezes while enable is low.
module seg7_step_div #(
   parameter int DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;
   logic          at_tc;

   assign at_tc = (cnt == CW'(DIV - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= at_tc ? '0 : cnt + CW'(1);
      end
   end

   // Gated by reset so no pulse escapes while the counter is being cleared
   assign tick = enable & at_tc & ~reset;

endmodule

// File: rtl/seg7_marquee_scroller.sv
// Scrolling-text driver: a writable message buffer shown through a window of
// NUM_DIGITS seven-segment digits that rotates at the step-divider rate.
module seg7_marquee_scroller
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int MSG_LEN    = 16,
   parameter int STEP_DIV   = 25000000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           dir,
   input  logic [$clog2(MSG_LEN+1)-1:0]   len_in,
   input  logic                           wr_en,
   input  logic [$clog2(MSG_LEN)-1:0]     wr_addr,
   input  logic [6:0]                     wr_data,
   output logic [7*NUM_DIGITS-1:0]        out,
   output logic [$clog2(MSG_LEN)-1:0]     pos,
   output logic                           step
);

   localparam int AW = $clog2(MSG_LEN);
   localparam int LW = $clog2(MSG_LEN + 1);
   localparam int OW = 7 * NUM_DIGITS;

   seg7_t          msg_q [MSG_LEN];
   logic [LW-1:0]  eff_len;
   logic [AW-1:0]  pos_nxt;
   logic [OW-1:0]  disp;
   logic           tick;
   int             pos_i;
   int             len_i;

   seg7_step_div #(.DIV(STEP_DIV)) u_step_div (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .tick   (tick)
   );

   assign step = tick;

   always_comb begin
      eff_len = len_in;
      if (len_in == '0 || int'(len_in) > MSG_LEN) begin
         eff_len = LW'(MSG_LEN);
      end
   end

   // An out-of-range head (length just shrank) snaps to 0 ahead of any step
   always_comb begin
      pos_i   = int'(pos);
      len_i   = int'(eff_len);
      pos_nxt = pos;
      if (pos_i >= len_i) begin
         pos_nxt = '0;
      end else if (tick) begin
         if (!dir) begin
            pos_nxt = (pos_i + 1 == len_i) ? '0 : AW'(pos_i + 1);
         end else begin
            pos_nxt = (pos_i == 0) ? AW'(len_i - 1) : AW'(pos_i - 1);
         end
      end
   end

   // Wrap pos+k into 0..L-1 by repeated subtraction; NUM_DIGITS passes cover L=1
   always_comb begin
      int base;
      int idx;
      base = (pos_i >= len_i) ? 0 : pos_i;
      idx  = 0;
      disp = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         idx = base + k;
         for (int j = 0; j < NUM_DIGITS; j++) begin
            if (idx >= len_i) begin
               idx = idx - len_i;
            end
         end
         disp[OW-1-7*k -: 7] = msg_q[AW'(idx)];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < MSG_LEN; i++) begin
            msg_q[i] <= SEG_BLANK;
         end
         pos <= '0;
         out <= (ACTIVE_LOW != 0) ? '1 : '0;
      end else begin
         for (int i = 0; i < MSG_LEN; i++) begin
            if (wr_en && wr_addr == AW'(i)) begin
               msg_q[i] <= wr_data;
            end
         end
         pos <= pos_nxt;
         out <= (ACTIVE_LOW != 0) ? ~disp : disp;
      end
   end

endmodule
